// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer driving the nco freq_res/phase tuning inputs.
// Optional phase hop on every frequency change: define NCO_SWEEP_PHASE_HOP_EN.
module nco_sweep_ctrl #(
  parameter int FREQ_W  = 6,
  parameter int PHASE_W = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [FREQ_W-1:0]  cfg_start_freq,
  input  logic [FREQ_W-1:0]  cfg_stop_freq,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_cont,
  input  logic [PHASE_W-1:0] cfg_phase,
  input  logic [PHASE_W-1:0] cfg_phase_step,
  output logic [FREQ_W-1:0]  freq_res,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state, w_state_nx;
  logic [FREQ_W-1:0]    r_freq, w_freq_nx;
  logic [PHASE_W-1:0]   r_phase, w_phase_nx;
  logic                 r_busy, w_busy_nx;
  logic                 r_done, w_done_nx;
  logic [DWELL_W-1:0]   r_cnt, w_cnt_nx;
  logic [FREQ_W-1:0]    r_start, w_start_nx;
  logic [FREQ_W-1:0]    r_stop, w_stop_nx;
  logic [FREQ_W-1:0]    r_step, w_step_nx;
  logic [DWELL_W-1:0]   r_dwell, w_dwell_nx;
  logic                 r_cont, w_cont_nx;
  logic                 r_up, w_up_nx;
  logic [PHASE_W-1:0]   w_phase_hop;

  // One extra bit catches both overshoot past the top and underflow below 0.
  logic [FREQ_W:0]      w_sum, w_diff;
  logic [FREQ_W-1:0]    w_step_val;

  assign w_sum  = {1'b0, r_freq} + {1'b0, r_step};
  assign w_diff = {1'b0, r_freq} - {1'b0, r_step};

  always_comb begin
    if (r_up)
      w_step_val = (w_sum > {1'b0, r_stop}) ? r_stop : w_sum[FREQ_W-1:0];
    else
      w_step_val = (w_diff[FREQ_W] || (w_diff[FREQ_W-1:0] < r_stop)) ? r_stop
                                                                    : w_diff[FREQ_W-1:0];
  end

`ifdef NCO_SWEEP_PHASE_HOP_EN
  logic [PHASE_W-1:0] r_pstep, w_pstep_nx;
  assign w_phase_hop = r_phase + r_pstep;
  assign w_pstep_nx  = (r_state == S_IDLE && start && !abort) ? cfg_phase_step : r_pstep;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_pstep <= '0;
    else      r_pstep <= w_pstep_nx;
`else
  // Port kept for interface compatibility; phase never moves after start.
  logic w_unused_pstep;
  assign w_unused_pstep = ^cfg_phase_step;
  assign w_phase_hop    = r_phase;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_freq_nx  = r_freq;
    w_phase_nx = r_phase;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_cnt_nx   = r_cnt;
    w_start_nx = r_start;
    w_stop_nx  = r_stop;
    w_step_nx  = r_step;
    w_dwell_nx = r_dwell;
    w_cont_nx  = r_cont;
    w_up_nx    = r_up;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_start_nx = cfg_start_freq;
          w_stop_nx  = cfg_stop_freq;
          w_step_nx  = (cfg_step == '0) ? FREQ_W'(1) : cfg_step;
          w_dwell_nx = cfg_dwell;
          w_cont_nx  = cfg_cont;
          w_up_nx    = (cfg_stop_freq >= cfg_start_freq);
          w_freq_nx  = cfg_start_freq;
          w_phase_nx = cfg_phase;
          w_cnt_nx   = cfg_dwell;
          w_busy_nx  = 1'b1;
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_busy_nx  = 1'b0;
          w_state_nx = S_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - 1'b1;
        end else if (r_freq != r_stop) begin
          w_freq_nx  = w_step_val;
          w_cnt_nx   = r_dwell;
          w_phase_nx = w_phase_hop;
        end else if (r_cont) begin
          w_freq_nx  = r_start;
          w_cnt_nx   = r_dwell;
          w_phase_nx = w_phase_hop;
        end else begin
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
          w_state_nx = S_DONE;
        end
      end
      default: begin
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_freq  <= FREQ_W'(1);
      r_phase <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_start <= '0;
      r_stop  <= '0;
      r_step  <= '0;
      r_dwell <= '0;
      r_cont  <= 1'b0;
      r_up    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_freq  <= w_freq_nx;
      r_phase <= w_phase_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_cnt   <= w_cnt_nx;
      r_start <= w_start_nx;
      r_stop  <= w_stop_nx;
      r_step  <= w_step_nx;
      r_dwell <= w_dwell_nx;
      r_cont  <= w_cont_nx;
      r_up    <= w_up_nx;
    end
  end

  assign freq_res = r_freq;
  assign phase    = r_phase;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl with hand-computed sweep sequences.
module tb_nco_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, cfg_cont;
  logic [5:0] cfg_start_freq, cfg_stop_freq, cfg_step;
  logic [15:0] cfg_dwell;
  logic [7:0] cfg_phase, cfg_phase_step;
  logic [5:0] freq_res;
  logic [7:0] phase;
  logic       busy, done;

  int n_chk = 0;
  int n_err = 0;

  nco_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_start_freq(cfg_start_freq), .cfg_stop_freq(cfg_stop_freq),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_cont(cfg_cont),
    .cfg_phase(cfg_phase), .cfg_phase_step(cfg_phase_step),
    .freq_res(freq_res), .phase(phase), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [5:0] s, input logic [5:0] e, input logic [5:0] st,
                     input logic [15:0] dw, input logic c, input logic [7:0] ph,
                     input logic [7:0] ps);
    cfg_start_freq = s; cfg_stop_freq = e; cfg_step = st;
    cfg_dwell = dw; cfg_cont = c; cfg_phase = ph; cfg_phase_step = ps;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Check a held value for n cycles, advancing one clock after each check.
  task automatic hold(input string tag, input logic [5:0] f, input logic [7:0] ph, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_freq"}, freq_res, f);
      chk({tag, "_phase"}, phase, ph);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_done"}, done, 1'b0);
      tick();
    end
  endtask

  task automatic expect_done(input string tag, input logic [5:0] f, input logic [7:0] ph);
    chk({tag, "_done_hi"}, done, 1'b1);
    chk({tag, "_busy_lo"}, busy, 1'b0);
    chk({tag, "_freq_hold"}, freq_res, f);
    chk({tag, "_phase_hold"}, phase, ph);
    tick();
    chk({tag, "_done_lo"}, done, 1'b0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  logic [7:0] ph1, ph2;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    cfg(6'd0, 6'd0, 6'd0, 16'd0, 1'b0, 8'h00, 8'h00);
    #23;
    chk("rst_freq", freq_res, 6'd1);
    chk("rst_phase", phase, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk); rst = 1'b1;
    tick(); tick(); tick();
    chk("idle_freq", freq_res, 6'd1);
    chk("idle_busy", busy, 1'b0);

    // Up sweep, later cfg changes and a stray start must be ignored.
    cfg(6'd2, 6'd10, 6'd3, 16'd4, 1'b0, 8'h33, 8'h00);
    go();
    cfg(6'd50, 6'd0, 6'd7, 16'd0, 1'b1, 8'hAA, 8'h11);
    hold("up2", 6'd2, 8'h33, 2);
    start = 1'b1;
    hold("up2b", 6'd2, 8'h33, 1);
    start = 1'b0;
    hold("up2c", 6'd2, 8'h33, 2);
    hold("up5", 6'd5, 8'h33, 5);
    hold("up8", 6'd8, 8'h33, 5);
    hold("up10", 6'd10, 8'h33, 5);
    expect_done("up", 6'd10, 8'h33);

    // Down sweep with clamp to stop, dwell 0.
    cfg(6'd60, 6'd5, 6'd20, 16'd0, 1'b0, 8'h21, 8'h00);
    go();
    hold("dn60", 6'd60, 8'h21, 1);
    hold("dn40", 6'd40, 8'h21, 1);
    hold("dn20", 6'd20, 8'h21, 1);
    hold("dn5", 6'd5, 8'h21, 1);
    expect_done("dn", 6'd5, 8'h21);

    // Continuous sawtooth, step 0 acts as 1, then abort.
    cfg(6'd1, 6'd4, 6'd0, 16'd1, 1'b1, 8'h40, 8'h00);
    go();
    hold("ct1", 6'd1, 8'h40, 2);
    hold("ct2", 6'd2, 8'h40, 2);
    hold("ct3", 6'd3, 8'h40, 2);
    hold("ct4", 6'd4, 8'h40, 2);
    hold("ct1b", 6'd1, 8'h40, 2);
    hold("ct2b", 6'd2, 8'h40, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_freq", freq_res, 6'd2);
    tick(); tick();
    chk("abort_idle_freq", freq_res, 6'd2);
    chk("abort_idle_busy", busy, 1'b0);

    // start with abort in IDLE is ignored.
    cfg(6'd7, 6'd9, 6'd1, 16'd0, 1'b0, 8'h55, 8'h00);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 1'b0);
    chk("sa_freq", freq_res, 6'd2);
    tick();
    chk("sa_freq2", freq_res, 6'd2);

    // start == stop: single hold of dwell+1 cycles.
    cfg(6'd9, 6'd9, 6'd4, 16'd2, 1'b0, 8'h66, 8'h00);
    go();
    hold("eq9", 6'd9, 8'h66, 3);
    expect_done("eq", 6'd9, 8'h66);

    // Reset mid-run returns to reset values immediately, no done.
    cfg(6'd30, 6'd40, 6'd1, 16'd3, 1'b0, 8'h77, 8'h00);
    go();
    hold("rr30", 6'd30, 8'h77, 2);
    #2 rst = 1'b0;
    #1;
    chk("mrst_freq", freq_res, 6'd1);
    chk("mrst_phase", phase, 8'h00);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    @(negedge clk); rst = 1'b1;
    tick(); tick();
    chk("mrst_idle_freq", freq_res, 6'd1);
    chk("mrst_idle_done", done, 1'b0);

    // Phase hop sequence.
`ifdef NCO_SWEEP_PHASE_HOP_EN
    ph1 = 8'h08; ph2 = 8'h00;
`else
    ph1 = 8'h10; ph2 = 8'h10;
`endif
    cfg(6'd0, 6'd2, 6'd1, 16'd0, 1'b0, 8'h10, 8'hF8);
    go();
    hold("ph0", 6'd0, 8'h10, 1);
    hold("ph1", 6'd1, ph1, 1);
    hold("ph2", 6'd2, ph2, 1);
    expect_done("ph", 6'd2, ph2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
